// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, bus word types, request bundle.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

   localparam int ARB_ADDR_W = 8;
   localparam int ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_INST,
      ARB_DATA
   } ArbState;

   typedef logic [ARB_ADDR_W-1:0] MemAddr;
   typedef logic [ARB_DATA_W-1:0] Word;

   typedef struct packed {
      logic   req;
      logic   we;
      MemAddr addr;
      Word    wdata;
   } ArbReq;

endpackage

// File: rtl/mem_arb_timer.sv
// Access sequencer: counts the cycles of one memory access from its grant edge.
// Latency: issue in the first cycle after start, done MEM_LAT cycles later.
// Backpressure: none; start is only honoured while idle.
module mem_arb_timer #(
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic issue,
   output logic done
);
   import mem_port_arbiter_pkg::*;

   logic [3:0] cnt;

   // cnt starts at 0 on the grant edge and steps once per cycle until data is due
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start && !busy) begin
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         if (done) begin
            cnt  <= '0;
            busy <= 1'b0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   assign issue = busy && (cnt == 4'd0);
   assign done  = busy && (cnt == 4'(MEM_LAT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and data ports; optional fairness via MEM_ARB_FAIR_EN.
// Latency: req at t -> mem_en at t+1 -> valid pulse at t+2+MEM_LAT; grants spaced MEM_LAT+2 apart.
// Backpressure: requesters hold req until their valid pulse; stall_if/stall_m flag the wait.
module mem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
`ifdef MEM_ARB_FAIR_EN
   parameter int STARVE_LIM = 4,
`endif
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_m
);
   import mem_port_arbiter_pkg::*;

   ArbState           state;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              flush_flag;
   logic              i_elig;
   logic              d_elig;
   logic              grant_i;
   logic              grant_d;
   logic              t_busy;
   logic              t_issue;
   logic              t_done;
   logic              idle;

   // A port that just got its valid pulse is still showing the old request, so mask it.
   assign idle   = (state == ARB_IDLE);
   assign i_elig = if_req & ~if_valid & ~if_flush;
   assign d_elig = d_req & ~d_valid;

`ifdef MEM_ARB_FAIR_EN
   localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

   logic [SW-1:0] starve_cnt;
   logic          fetch_turn;

   assign fetch_turn = (starve_cnt == SW'(STARVE_LIM)) & i_elig & d_elig;
   assign grant_d    = idle & d_elig & ~fetch_turn;
   assign grant_i    = idle & i_elig & (~d_elig | fetch_turn);

   // count data grants that bypassed a waiting fetch; saturates at the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d && if_req && (starve_cnt != SW'(STARVE_LIM))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign grant_d = idle & d_elig;
   assign grant_i = idle & i_elig & ~d_elig;
`endif

   mem_arb_timer #(
      .MEM_LAT(MEM_LAT)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .start (grant_i | grant_d),
      .busy  (t_busy),
      .issue (t_issue),
      .done  (t_done)
   );

   // arbitration FSM: latch the winner, then return data and pulse valid when the timer expires
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         flush_flag <= 1'b0;
         if_valid   <= 1'b0;
         d_valid    <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         case (state)
            ARB_IDLE: begin
               flush_flag <= 1'b0;
               if (grant_d) begin
                  state     <= ARB_DATA;
                  lat_we    <= d_we;
                  lat_addr  <= d_addr;
                  lat_wdata <= d_wdata;
               end else if (grant_i) begin
                  state     <= ARB_INST;
                  lat_we    <= 1'b0;
                  lat_addr  <= if_addr;
                  lat_wdata <= '0;
               end
            end
            ARB_INST: begin
               if (if_flush) begin
                  flush_flag <= 1'b1;
               end
               if (t_done) begin
                  state      <= ARB_IDLE;
                  flush_flag <= 1'b0;
                  // a killed fetch still occupies the memory but must not reach the pipeline
                  if (!(flush_flag || if_flush)) begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end
            end
            ARB_DATA: begin
               if (t_done) begin
                  state   <= ARB_IDLE;
                  d_valid <= 1'b1;
                  if (!lat_we) begin
                     d_rdata <= mem_rdata;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign mem_en    = t_issue;
   assign mem_we    = t_busy & lat_we;
   assign mem_addr  = t_busy ? lat_addr : '0;
   assign mem_wdata = t_busy ? lat_wdata : '0;

   assign stall_if = if_req & ~if_valid;
   assign stall_m  = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory model.
// Latency: expects mem_en at t+1 and valid at t+2+LAT for a request at t.
// Backpressure: requesters hold req until their valid pulse, as the pipeline does.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        if_flush;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [7:0]  d_addr;
   logic [31:0] d_wdata;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_m;

   int cyc = 0;
   int n_checks = 0;
   int n_errs = 0;

   typedef struct {
      int          cyc;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } rsp_exp_t;

   mem_exp_t    exp_mem[$];
   rsp_exp_t    exp_if[$];
   rsp_exp_t    exp_d[$];
   rsp_exp_t    rd_q[$];
   logic [31:0] mem [256];
   logic [31:0] d_rdata_model;
   logic [31:0] if_rdata_model;

   mem_port_arbiter #(
      .ADDR_W(8),
      .DATA_W(32),
`ifdef MEM_ARB_FAIR_EN
      .STARVE_LIM(2),
`endif
      .MEM_LAT(LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_valid  (if_valid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_if  (stall_if),
      .stall_m   (stall_m)
   );

   initial begin
      forever begin
         #5 clk = 1'b1;
         cyc = cyc + 1;
         #5 clk = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic go(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_access(input int c, input logic we, input logic [7:0] a, input logic [31:0] wd);
      mem_exp_t e;
      e.cyc = c; e.we = we; e.addr = a; e.wdata = wd;
      exp_mem.push_back(e);
   endtask

   task automatic exp_ifv(input int c, input logic [31:0] dat);
      rsp_exp_t e;
      e.cyc = c; e.data = dat;
      exp_if.push_back(e);
   endtask

   task automatic exp_dv(input int c, input logic [31:0] dat);
      rsp_exp_t e;
      e.cyc = c; e.data = dat;
      exp_d.push_back(e);
   endtask

   // compare every memory strobe and valid pulse against the queued expectations
   task automatic monitor_cycle();
      mem_exp_t m;
      rsp_exp_t r;
      if (mem_en) begin
         if (exp_mem.size() == 0) begin
            check("mem_en_unexpected", 64'(mem_en), 64'(0));
         end else begin
            m = exp_mem.pop_front();
            check("mem_cycle", 64'(cyc), 64'(m.cyc));
            check("mem_addr", 64'(mem_addr), 64'(m.addr));
            check("mem_we", 64'(mem_we), 64'(m.we));
            if (m.we) check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
         end
         if (mem_we) begin
            mem[mem_addr] = mem_wdata;
         end else begin
            r.cyc = cyc + LAT; r.data = mem[mem_addr];
            rd_q.push_back(r);
         end
      end
      if (if_valid) begin
         if (exp_if.size() == 0) begin
            check("if_valid_unexpected", 64'(if_valid), 64'(0));
         end else begin
            r = exp_if.pop_front();
            check("if_valid_cycle", 64'(cyc), 64'(r.cyc));
            check("if_rdata", 64'(if_rdata), 64'(r.data));
         end
      end
      if (d_valid) begin
         if (exp_d.size() == 0) begin
            check("d_valid_unexpected", 64'(d_valid), 64'(0));
         end else begin
            r = exp_d.pop_front();
            check("d_valid_cycle", 64'(cyc), 64'(r.cyc));
            check("d_rdata", 64'(d_rdata), 64'(r.data));
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         monitor_cycle();
      end
   end

   // memory model: read data appears exactly LAT cycles after the strobe, junk otherwise
   initial begin
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         while (rd_q.size() > 0 && rd_q[0].cyc < cyc) void'(rd_q.pop_front());
         if (rd_q.size() > 0 && rd_q[0].cyc == cyc) mem_rdata = rd_q[0].data;
         else mem_rdata = 32'hBAD0_0000 | 32'(cyc);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      go(cyc + 2);
      rst = 1'b0;
      d_rdata_model = '0;
      if_rdata_model = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_en"}, 64'(mem_en), 64'(0));
      check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
      check({tag, "_if_valid"}, 64'(if_valid), 64'(0));
      check({tag, "_d_valid"}, 64'(d_valid), 64'(0));
      check({tag, "_if_rdata"}, 64'(if_rdata), 64'(0));
      check({tag, "_d_rdata"}, 64'(d_rdata), 64'(0));
      check({tag, "_stall_if"}, 64'(stall_if), 64'(0));
      check({tag, "_stall_m"}, 64'(stall_m), 64'(0));
   endtask

   initial begin
      int b;
      int stall_cnt;
      int exp_stall;
      for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i), 8'h5A, 8'(i)};
      mem[8'h10] = 32'hDEAD_BEEF;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      d_rdata_model = '0; if_rdata_model = '0;
      go(2);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      go(4);

      // lone fetch: stall for four cycles, then instruction with valid
      b = cyc;
      if_req = 1'b1; if_addr = 8'h10;
      exp_access(b + 1, 1'b0, 8'h10, '0);
      exp_ifv(b + 4, 32'hDEAD_BEEF);
      if_rdata_model = 32'hDEAD_BEEF;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         check("t1_stall_if", 64'(stall_if), 64'(k < 4));
         go(b + k + 1);
      end
      if_req = 1'b0;
      go(b + 8);

      // simultaneous requests: data first, fetch one slot later
      b = cyc;
      if_req = 1'b1; if_addr = 8'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; d_wdata = '0;
      exp_access(b + 1, 1'b0, 8'h20, '0);
      exp_access(b + 5, 1'b0, 8'h10, '0);
      exp_dv(b + 4, mem[8'h20]);
      exp_ifv(b + 8, mem[8'h10]);
      d_rdata_model = mem[8'h20];
      go(b + 2);
      @(negedge clk);
      check("t2_stall_m_wait", 64'(stall_m), 64'(1));
      go(b + 4);
      @(negedge clk);
      check("t2_stall_m_done", 64'(stall_m), 64'(0));
      go(b + 5);
      d_req = 1'b0;
      go(b + 9);
      if_req = 1'b0;
      go(b + 10);

      // data write: strobe carries write data, d_rdata keeps previous read
      b = cyc;
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_wdata = 32'h0000_1234;
      exp_access(b + 1, 1'b1, 8'h05, 32'h0000_1234);
      exp_dv(b + 4, d_rdata_model);
      go(b + 5);
      d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
      go(b + 6);

      // flushed fetch: no valid for 0x10, redirected fetch to 0x40 follows
      b = cyc;
      if_req = 1'b1; if_addr = 8'h10;
      exp_access(b + 1, 1'b0, 8'h10, '0);
      exp_access(b + 5, 1'b0, 8'h40, '0);
      exp_ifv(b + 8, mem[8'h40]);
      go(b + 2);
      if_flush = 1'b1;
      go(b + 3);
      if_flush = 1'b0; if_addr = 8'h40;
      go(b + 5);
      @(negedge clk);
      check("t4_if_rdata_kept", 64'(if_rdata), 64'(if_rdata_model));
      go(b + 9);
      if_req = 1'b0;
      if_rdata_model = mem[8'h40];
      go(b + 10);

      // reset in the middle of a data read abandons it
      b = cyc;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      exp_access(b + 1, 1'b0, 8'h20, '0);
      go(b + 2);
      rst = 1'b1; d_req = 1'b0;
      go(b + 3);
      rst = 1'b0;
      d_rdata_model = '0; if_rdata_model = '0;
      @(negedge clk);
      check_all_zero("t5");
      go(b + 10);

      // contention: fetch is flushed whenever data completes, so data competes every slot
      do_reset();
      b = cyc;
      if_req = 1'b1; if_addr = 8'h30;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h31; d_wdata = '0;
`ifdef MEM_ARB_FAIR_EN
      begin
         int  off[7];
         bit  is_i[7];
         int  dv[5];
         off  = '{1, 6, 11, 15, 20, 25, 29};
         is_i = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         dv   = '{4, 9, 18, 23, 32};
         for (int i = 0; i < 7; i++) exp_access(b + off[i], 1'b0, is_i[i] ? 8'h30 : 8'h31, '0);
         for (int i = 0; i < 5; i++) exp_dv(b + dv[i], mem[8'h31]);
         exp_ifv(b + 14, mem[8'h30]);
         exp_ifv(b + 28, mem[8'h30]);
         exp_stall = 27;
      end
`else
      for (int i = 0; i < 6; i++) begin
         exp_access(b + 1 + 5 * i, 1'b0, 8'h31, '0);
         exp_dv(b + 4 + 5 * i, mem[8'h31]);
      end
      exp_stall = 29;
`endif
      stall_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         if_flush = d_valid;
         if (k == 29) begin
            if_req = 1'b0;
            d_req = 1'b0;
         end
         @(negedge clk);
         if (k < 29 && stall_if) stall_cnt++;
         go(b + k + 1);
      end
      if_flush = 1'b0;
      check("t6_stall_if_cycles", 64'(stall_cnt), 64'(exp_stall));
      go(b + 38);

      check("leftover_expectations", 64'(exp_mem.size() + exp_if.size() + exp_d.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
